// File: rtl/lbm_pkg.sv
// Shared fixed-point types and constants for the LBM moment/velocity datapath.
// Latency: n/a (types only).
// Backpressure: n/a.
package lbm_pkg;

    localparam int LBM_DATA_WIDTH = 32;
    localparam int LBM_FRAC_BITS  = 16;

    typedef logic signed [LBM_DATA_WIDTH-1:0] fix_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } div_state_t;

    localparam fix_t FIX_MAX = {1'b0, {(LBM_DATA_WIDTH-1){1'b1}}};
    localparam fix_t FIX_MIN = {1'b1, {(LBM_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_lane.sv
// Unsigned restoring divider lane: one quotient bit per step.
// Latency: DIV_ITERS steps after load.
// Backpressure: none; advances only while step is high.
module div_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_ITERS  = 48
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DIV_ITERS-1:0]  dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DIV_ITERS-1:0]  quotient
);

    logic [DATA_WIDTH:0]   rem_q;
    logic [DIV_ITERS-1:0]  dvd_q;
    logic [DIV_ITERS-1:0]  quo_q;
    logic [DATA_WIDTH+1:0] rem_sh;
    logic [DATA_WIDTH:0]   rem_d;
    logic                  fits;

    // The remainder stays below the divisor, so its top bit only matters
    // transiently after the shift; the compare sees the full shifted value.
    always_comb begin
        rem_sh = {rem_q, dvd_q[DIV_ITERS-1]};
        fits   = (rem_sh >= {2'b00, divisor});
        rem_d  = fits ? (rem_sh[DATA_WIDTH:0] - {1'b0, divisor})
                      : rem_sh[DATA_WIDTH:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rem_q <= '0;
            dvd_q <= '0;
            quo_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            dvd_q <= dividend;
            quo_q <= '0;
        end else if (step) begin
            rem_q <= rem_d;
            dvd_q <= {dvd_q[DIV_ITERS-2:0], 1'b0};
            quo_q <= {quo_q[DIV_ITERS-2:0], fits};
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/velocity_divider.sv
// Two-lane signed fixed-point divider (ux = pux/p, uy = puy/p) sharing one divisor.
// Latency: div_valid exactly DIV_ITERS+2 cycles after the accepting edge.
// Backpressure: none; div_start outside IDLE is dropped, not queued.
module velocity_divider
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = LBM_DATA_WIDTH,
    parameter int FRAC_BITS  = LBM_FRAC_BITS,
    parameter int DIV_ITERS  = DATA_WIDTH + FRAC_BITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] p_in,
    input  logic [DATA_WIDTH-1:0] pux_in,
    input  logic [DATA_WIDTH-1:0] puy_in,
    output logic [DATA_WIDTH-1:0] ux_out,
    output logic [DATA_WIDTH-1:0] uy_out,
    output logic                  div_valid,
    output logic                  busy,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // 0x800..0 maps to 2^(W-1), still representable when read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] finish_lane(
        input logic [DIV_ITERS-1:0] q,
        input logic                 num_neg,
        input logic                 num_zero,
        input logic                 res_neg,
        input logic                 den_zero
    );
        logic [DATA_WIDTH-1:0] q_lo;
        q_lo = q[DATA_WIDTH-1:0];
        if (den_zero)
            return num_zero ? '0 : (num_neg ? SAT_NEG : SAT_POS);
        if (|q[DIV_ITERS-1:DATA_WIDTH-1])
            return res_neg ? SAT_NEG : SAT_POS;
        return res_neg ? -q_lo : q_lo;
    endfunction

    div_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] den_q;
    logic                  den_neg_q, x_neg_q, y_neg_q, x_zero_q, y_zero_q;
    logic [DIV_ITERS-1:0]  dvd_x, dvd_y, quo_x, quo_y;
    logic [DATA_WIDTH-1:0] res_x, res_y;
    logic                  accept, den_zero, sat_x, sat_y;

    assign accept   = (state_q == IDLE) && div_start;
    assign den_zero = (den_q == '0);
    assign busy     = (state_q == ITER) || (state_q == FIX);

    assign dvd_x = DIV_ITERS'({magnitude(pux_in), {FRAC_BITS{1'b0}}});
    assign dvd_y = DIV_ITERS'({magnitude(puy_in), {FRAC_BITS{1'b0}}});

    div_lane #(.DATA_WIDTH(DATA_WIDTH), .DIV_ITERS(DIV_ITERS)) u_lane_x (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (accept),
        .step     (state_q == ITER),
        .dividend (dvd_x),
        .divisor  (den_q),
        .quotient (quo_x)
    );

    div_lane #(.DATA_WIDTH(DATA_WIDTH), .DIV_ITERS(DIV_ITERS)) u_lane_y (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (accept),
        .step     (state_q == ITER),
        .dividend (dvd_y),
        .divisor  (den_q),
        .quotient (quo_y)
    );

    always_comb begin
        sat_x = |quo_x[DIV_ITERS-1:DATA_WIDTH-1];
        sat_y = |quo_y[DIV_ITERS-1:DATA_WIDTH-1];
        res_x = finish_lane(quo_x, x_neg_q, x_zero_q, x_neg_q ^ den_neg_q, den_zero);
        res_y = finish_lane(quo_y, y_neg_q, y_zero_q, y_neg_q ^ den_neg_q, den_zero);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_start) state_d = ITER;
            ITER:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A zero divisor still walks the full count so latency never varies.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            den_q     <= '0;
            den_neg_q <= 1'b0;
            x_neg_q   <= 1'b0;
            y_neg_q   <= 1'b0;
            x_zero_q  <= 1'b0;
            y_zero_q  <= 1'b0;
        end else if (accept) begin
            cnt_q     <= CNT_W'(DIV_ITERS - 1);
            den_q     <= magnitude(p_in);
            den_neg_q <= p_in[DATA_WIDTH-1];
            x_neg_q   <= pux_in[DATA_WIDTH-1];
            y_neg_q   <= puy_in[DATA_WIDTH-1];
            x_zero_q  <= (pux_in == '0);
            y_zero_q  <= (puy_in == '0);
        end else if ((state_q == ITER) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ux_out      <= '0;
            uy_out      <= '0;
            div_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            div_valid <= (state_q == DONE);
            if (state_q == DONE) begin
                ux_out <= res_x;
                uy_out <= res_y;
            end
            if (accept) begin
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end else if (state_q == FIX) begin
                div_by_zero <= den_zero;
                overflow    <= !den_zero && (sat_x || sat_y);
            end
        end
    end

endmodule

// File: tb/tb_velocity_divider.sv
// Randomised and directed checks of velocity_divider against an arithmetic reference.
module tb_velocity_divider;

    localparam int LAT = 50;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] p_in = '0, pux_in = '0, puy_in = '0;
    logic [31:0] ux_out, uy_out;
    logic        div_valid, busy, div_by_zero, overflow;

    always #5 Clk = ~Clk;

    velocity_divider dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .div_start   (div_start),
        .p_in        (p_in),
        .pux_in      (pux_in),
        .puy_in      (puy_in),
        .ux_out      (ux_out),
        .uy_out      (uy_out),
        .div_valid   (div_valid),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Q15.16 quotient from plain integer arithmetic, truncated toward zero.
    function automatic logic [31:0] ref_div(input logic [31:0] num, input logic [31:0] den,
                                            output logic ov);
        longint sn = longint'($signed(num));
        longint sd = longint'($signed(den));
        longint an = (sn < 0) ? -sn : sn;
        longint ad = (sd < 0) ? -sd : sd;
        logic   neg = (sn < 0) != (sd < 0);
        longint q;
        ov = 1'b0;
        if (ad == 0)
            return (sn == 0) ? 32'h0 : ((sn < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
        q = (an * 65536) / ad;
        if (q > 64'sd2147483647) begin
            ov = 1'b1;
            return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return neg ? 32'(-q) : 32'(q);
    endfunction

    // Reference: one operation in flight, result visible LAT edges after acceptance.
    int          since = -1;
    logic [31:0] m_ux = '0, m_uy = '0, pend_ux, pend_uy;
    logic        m_dz = 1'b0, m_ov = 1'b0, pend_dz, pend_ov, m_valid = 1'b0;

    always @(posedge Clk or negedge Reset) begin
        logic ovx, ovy;
        if (!Reset) begin
            since = -1; m_ux = '0; m_uy = '0; m_dz = 1'b0; m_ov = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (since >= 0) begin
                since++;
                if (since == LAT) begin
                    m_ux = pend_ux; m_uy = pend_uy; m_dz = pend_dz; m_ov = pend_ov;
                    m_valid = 1'b1;
                    since = -1;
                end
            end else if (div_start) begin
                since   = 0;
                pend_ux = ref_div(pux_in, p_in, ovx);
                pend_uy = ref_div(puy_in, p_in, ovy);
                pend_dz = (p_in == 32'h0);
                pend_ov = ovx | ovy;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("valid", div_valid, m_valid);
            check("busy", busy, (since >= 0) && (since <= LAT - 2));
            check("ux", ux_out, m_ux);
            check("uy", uy_out, m_uy);
            if (m_valid) begin
                check("div_by_zero", div_by_zero, m_dz);
                check("overflow", overflow, m_ov);
            end
        end
    end

    task automatic start_op(input logic [31:0] p, input logic [31:0] x, input logic [31:0] y);
        @(negedge Clk);
        p_in = p; pux_in = x; puy_in = y; div_start = 1'b1;
        @(negedge Clk);
        div_start = 1'b0;
        p_in = $urandom; pux_in = $urandom; puy_in = $urandom;
    endtask

    // Waits a bounded number of cycles; poke>0 fires an extra start pulse at that cycle.
    task automatic wait_valid(input int poke, output int lat, output int busy_low);
        lat = 0;
        busy_low = 0;
        for (int i = 1; i <= LAT + 10 && lat == 0; i++) begin
            @(negedge Clk);
            div_start = (i == poke);
            if (div_start) begin
                p_in = $urandom; pux_in = $urandom; puy_in = $urandom;
            end
            if (i <= LAT - 2 && !busy) busy_low++;
            if (div_valid) lat = i;
        end
        div_start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] p, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ex, input logic [31:0] ey,
                          input logic edz, input logic eov, input int poke);
        int lat, busy_low;
        start_op(p, x, y);
        wait_valid(poke, lat, busy_low);
        check({name, "_latency"}, lat, LAT);
        check({name, "_busy_gaps"}, busy_low, 0);
        check({name, "_busy_at_valid"}, busy, 0);
        check({name, "_ux"}, ux_out, ex);
        check({name, "_uy"}, uy_out, ey);
        check({name, "_dz"}, div_by_zero, edz);
        check({name, "_ov"}, overflow, eov);
        check({name, "_model_ux"}, m_ux, ex);
        check({name, "_model_uy"}, m_uy, ey);
        @(negedge Clk);
        check({name, "_pulse"}, div_valid, 0);
    endtask

    function automatic logic [31:0] rnd_num();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'h0;
            1:       v = $urandom;
            2:       v = 32'($urandom_range(0, 32'h3FFFF));
            3:       v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: v = 32'($urandom_range(0, 32'hFFFFF));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        int nv;
        #12;
        check("rst_ux", ux_out, 0);
        check("rst_uy", uy_out, 0);
        check("rst_valid", div_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ov", overflow, 0);
        @(negedge Clk);
        Reset = 1'b1;
        chk_en = 1'b1;

        run_op("basic",   32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 0, 0, 0);
        run_op("third",   32'h0003_0000, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_AAAB, 32'h0000_5555, 0, 0, 0);
        run_op("neg",     32'h0002_0000, 32'hFFFF_0000, 32'hFFFD_0000, 32'hFFFF_8000, 32'hFFFE_8000, 0, 0, 0);
        run_op("dz_pos",  32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1, 0, 0);
        run_op("dz_neg",  32'h0000_0000, 32'hFFFF_0000, 32'h0000_0002, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0);
        run_op("ovf",     32'h0000_0001, 32'h0001_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1, 0);
        run_op("negden",  32'hFFFE_0000, 32'h8000_0000, 32'h0001_0000, 32'h4000_0000, 32'hFFFF_8000, 0, 0, 0);
        run_op("minden",  32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000, 32'hFFFF_0001, 0, 0, 0);

        run_op("busy_start", 32'h0002_0000, 32'h0001_0000, 32'hFFFD_0000,
               32'h0000_8000, 32'hFFFE_8000, 0, 0, 10);
        nv = 0;
        repeat (LAT + 5) begin
            @(negedge Clk);
            if (div_valid) nv++;
        end
        check("busy_start_extra_valid", nv, 0);

        start_op(32'h0001_0000, 32'h0005_0000, 32'h0007_0000);
        repeat (20) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("midrst_ux", ux_out, 0);
        check("midrst_uy", uy_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", div_valid, 0);
        @(negedge Clk);
        #2 Reset = 1'b1;
        nv = 0;
        repeat (LAT + 10) begin
            @(negedge Clk);
            if (div_valid) nv++;
        end
        check("midrst_no_valid", nv, 0);
        run_op("after_rst", 32'h0004_0000, 32'h0001_0000, 32'hFFFF_E000,
               32'h0000_4000, 32'hFFFF_F800, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] rp, rx, ry, ex, ey;
            logic        ovx, ovy;
            int          poke;
            case ($urandom_range(0, 4))
                0:       rp = 32'h0;
                1:       rp = 32'($urandom_range(1, 255));
                2:       rp = $urandom;
                default: rp = 32'($urandom_range(32'h100, 32'h40000));
            endcase
            if ($urandom_range(0, 1) == 1) rp = -rp;
            rx = rnd_num();
            ry = rnd_num();
            ex = ref_div(rx, rp, ovx);
            ey = ref_div(ry, rp, ovy);
            poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT - 1) : 0;
            run_op("rand", rp, rx, ry, ex, ey, rp == 32'h0, ovx | ovy, poke);
            repeat ($urandom_range(0, 3)) @(negedge Clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
